// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Shares one memory bus between instruction fetch and MEM-stage
//               data access. Builds the 6-bit pipeline stall vector.
// Revision    : 1.0
// ============================================================================
module mem_bus_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        flush,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [5:0]  stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_stb_q, bus_stb_d;
    logic        bus_we_q, bus_we_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        d_done_q, d_done_d;
    logic        i_valid_q, i_valid_d;
    logic        discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stallreq_mem;
    logic stallreq_if;
    logic term_cnt;
    logic drop_fetch;

    assign stallreq_mem = mem_req & ~d_done_q;
    assign stallreq_if  = if_req & ~i_valid_q;
    assign term_cnt     = (cnt_q == CNT_W'(TIMEOUT - 1));
    // A flush arriving together with the ack still kills the fetched word.
    assign drop_fetch   = discard_q | flush;

    always_comb begin
        stall = 6'b000000;
        if (rst)               stall = 6'b000000;
        else if (stallreq_mem) stall = 6'b011111;
        else if (stallreq_ex)  stall = 6'b001111;
        else if (stallreq_id)  stall = 6'b000111;
        else if (stallreq_if)  stall = 6'b000011;
    end

    always_comb begin
        state_d     = state_q;
        bus_stb_d   = bus_stb_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        d_done_d    = 1'b0;
        discard_d   = discard_q;
        cnt_d       = '0;

        i_valid_d = i_valid_q;
        if (i_valid_q && !stall[1]) i_valid_d = 1'b0;
        if (flush)                  i_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req && !d_done_q) begin
                    bus_stb_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    state_d     = D_WAIT;
                end else if (if_req && !i_valid_q && !flush) begin
                    bus_stb_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = 4'b1111;
                    bus_addr_d = if_addr;
                    state_d    = I_WAIT;
                end
            end
            D_WAIT: begin
                if (bus_ack || term_cnt) begin
                    mem_rdata_d = (bus_ack && !bus_we_q) ? bus_rdata : 32'h0;
                    d_done_d    = 1'b1;
                    bus_err_d   = ~bus_ack;
                    bus_stb_d   = 1'b0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            I_WAIT: begin
                discard_d = drop_fetch;
                if (bus_ack || term_cnt) begin
                    if (!drop_fetch) begin
                        if_rdata_d = bus_ack ? bus_rdata : 32'h0;
                        i_valid_d  = 1'b1;
                    end
                    discard_d = 1'b0;
                    bus_err_d = ~bus_ack;
                    bus_stb_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_stb_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= 4'b0000;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
            d_done_q    <= 1'b0;
            i_valid_q   <= 1'b0;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bus_stb_q   <= bus_stb_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
            d_done_q    <= d_done_d;
            i_valid_q   <= i_valid_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_stb   = bus_stb_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_err   = bus_err_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequences the MIPS pipeline's single shared memory bus between instruction fetch (IF) and data access from the MEM stage.
- Merges the bus stall requests with the ID and EX stall requests into the 6-bit stall vector. That vector drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sits beside the pipeline registers.
- Stall convention:
  - stall[i]=1 and stall[i+1]=0 inserts a bubble after stage i.
  - stall[i]=1 and stall[i+1]=1 holds stage i.

Parameters:
- TIMEOUT, 255: bus cycles without bus_ack before the access is aborted.
- CNT_W, 8: width of the timeout counter. It must hold TIMEOUT.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_req  input  1  IF stage wants an instruction word
- if_addr  input  32  fetch address, equal to the PC
- if_rdata  output  32  buffered instruction word
- mem_req  input  1  MEM stage has a load or store
- mem_we  input  1  1 = store
- mem_sel  input  4  byte enables
- mem_addr  input  32  data address
- mem_wdata  input  32  store data
- mem_rdata  output  32  load data, valid while d_done=1
- stallreq_id  input  1  load-use stall request from ID
- stallreq_ex  input  1  multi-cycle stall request from EX
- flush  input  1  exception flush; discards the fetched or pending instruction
- bus_stb  output  1  bus request (cycle and strobe)
- bus_we  output  1  bus write enable
- bus_sel  output  4  bus byte enables
- bus_addr  output  32  bus address
- bus_wdata  output  32  bus write data
- bus_ack  input  1  bus completion
- bus_rdata  input  32  bus read data
- bus_err  output  1  one-cycle pulse on timeout abort
- stall  output  6  stall vector: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB

Behaviour:
- Reset: state=IDLE. All of the following are 0: bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata, bus_err, d_done, i_valid, discard, the timeout counter, and stall.
- Internal signals:
  - stallreq_mem = mem_req & ~d_done
  - stallreq_if = if_req & ~i_valid
- stall, combinational, first match wins:
  - stallreq_mem: 011111
  - stallreq_ex: 001111
  - stallreq_id: 000111
  - stallreq_if: 000011
  - otherwise: 000000
- FSM states: IDLE, D_WAIT, I_WAIT. All bus outputs are registered.
- IDLE:
  - If mem_req & ~d_done: latch mem_* onto the bus, set bus_stb=1, go to D_WAIT. Data has priority over fetch because MEM holds the older instruction.
  - Else if if_req & ~i_valid & ~flush: latch if_addr, set bus_we=0 and bus_sel=1111, set bus_stb=1, go to I_WAIT.
  - Else stay in IDLE.
- D_WAIT:
  - Bus outputs stay constant.
  - On bus_ack: set mem_rdata=bus_rdata (0 for a store), set d_done=1 for exactly the next cycle, set bus_stb=0, go to IDLE.
- I_WAIT:
  - On bus_ack: if discard=0, set if_rdata=bus_rdata and i_valid=1. Clear discard, set bus_stb=0, go to IDLE.
- Data latency: mem_req seen in IDLE at cycle 0 -> bus_stb=1 at cycle 1. An ack sampled at cycle k -> d_done=1 with valid mem_rdata at cycle k+1, and stall[4] released in that same cycle. Minimum 3 cycles.
- Consuming a fetched word: i_valid clears on the first cycle with i_valid=1 and stall[1]=0. if_rdata holds its value until then.
- Flush:
  - Clears i_valid.
  - In I_WAIT it sets discard; the access still completes and its data is dropped.
  - It does not abort a data access.
  - It blocks a new fetch issue in that cycle.
- Timeout:
  - The counter increments each cycle in D_WAIT or I_WAIT and clears on leaving those states.
  - When the counter reaches TIMEOUT-1 without ack: abort as if ack had arrived with rdata=0, and pulse bus_err=1 for one cycle.
- Simultaneous events:
  - bus_ack together with the timeout terminal count is treated as an ack (bus_err=0).
  - mem_req and if_req together in IDLE: data is issued; the fetch waits.
- d_done=1 suppresses re-issue for the instruction still presenting mem_req in that cycle.
- rst asserted mid-access returns everything to reset values on the next edge, with bus_stb=0. No outstanding-ack tracking.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000010, ack 2 cycles after stb with rdata=0x24010005 -> stall=000011 until if_rdata=0x24010005 with i_valid=1, then stall=000000 and i_valid clears the next cycle.
- Load: mem_req=1, mem_we=0, mem_addr=0x80, ack with 0xDEADBEEF on the 3rd stb cycle -> stall=011111 throughout. The next cycle has d_done=1, mem_rdata=0xDEADBEEF, stall=000000, and no re-issue.
- Contention: mem_req and if_req both rise in IDLE -> the data access (bus_we=1, bus_sel=0011 for a halfword store) is issued first. Fetch bus_stb rises only after d_done.
- Stall priority: stallreq_ex=1 with i_valid=1 -> stall=001111 and if_rdata is held. After stallreq_ex drops -> stall=000000 and i_valid clears.
- Flush during I_WAIT: flush pulse, then ack with 0x12345678 -> i_valid stays 0 and if_rdata is unchanged. The next fetch is issued from IDLE.
- Timeout with TIMEOUT=4 and no ack -> bus_stb drops after 4 cycles, bus_err pulses once, mem_rdata=0, d_done=1. A mid-access rst instead -> bus_stb=0 and stall=000000 the next cycle.
